// File: rtl/prt_scaler_pkg.sv
// rtl/prt_scaler_pkg.sv - shared types and table constants for the scaler coefficient sequencer
package prt_scaler_pkg;

   typedef enum logic [1:0] {
      MODE_3_2 = 2'd0,
      MODE_2_1 = 2'd1,
      MODE_3_1 = 2'd2,
      MODE_4_3 = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   localparam int COEF_CNT [4] = '{17, 3, 11, 76};
   localparam int ROM_LAT = 2;

   function automatic int coef_cnt(input logic [1:0] mode);
      return COEF_CNT[mode];
   endfunction

endpackage

// File: rtl/prt_scaler_coef_seq_if.sv
// rtl/prt_scaler_coef_seq_if.sv - coefficient stream towards the filter tap loader
interface prt_scaler_coef_seq_if #(
   parameter int P_IDX = 7,
   parameter int P_DAT = 8
);
   logic [P_DAT-1:0] COEF_DAT_OUT;
   logic [P_IDX-1:0] COEF_IDX_OUT;
   logic             COEF_LST_OUT;
   logic             COEF_VLD_OUT;
   logic             COEF_RDY_IN;

   modport master (
      output COEF_DAT_OUT,
      output COEF_IDX_OUT,
      output COEF_LST_OUT,
      output COEF_VLD_OUT,
      input  COEF_RDY_IN
   );

   modport slave (
      input  COEF_DAT_OUT,
      input  COEF_IDX_OUT,
      input  COEF_LST_OUT,
      input  COEF_VLD_OUT,
      output COEF_RDY_IN
   );
endinterface

// File: rtl/prt_scaler_coef_fifo.sv
// rtl/prt_scaler_coef_fifo.sv - first-word fall-through FIFO with synchronous flush and fill count
module prt_scaler_coef_fifo #(
   parameter int P_W     = 16,
   parameter int P_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       wr_en,
   input  logic [P_W-1:0]             wr_data,
   input  logic                       rd_en,
   output logic [P_W-1:0]             rd_data,
   output logic                       empty,
   output logic [$clog2(P_DEPTH):0]   count
);
   localparam int AW = $clog2(P_DEPTH);
   localparam int CW = AW + 1;

   logic [P_W-1:0] mem_q [P_DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           do_wr, do_rd;

   always_comb begin
      do_wr    = wr_en && !flush && (cnt_q != CW'(P_DEPTH));
      do_rd    = rd_en && !flush && (cnt_q != '0);
      wr_ptr_d = wr_ptr_q + AW'(do_wr);
      rd_ptr_d = rd_ptr_q + AW'(do_rd);
      cnt_d    = cnt_q + CW'(do_wr) - CW'(do_rd);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: nothing reads an entry before it is written.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign empty   = (cnt_q == '0);
   assign count   = cnt_q;

endmodule

// File: rtl/prt_scaler_coef_seq.sv
// rtl/prt_scaler_coef_seq.sv - walks the coefficient ROM for one ratio mode and streams the words out
module prt_scaler_coef_seq
   import prt_scaler_pkg::*;
#(
   parameter int P_MODE = 2,
   parameter int P_IDX  = 7,
   parameter int P_DAT  = 8,
   parameter int P_LAT  = ROM_LAT,
   parameter int P_FIFO = 8
) (
   input  logic                      CLK_IN,
   input  logic                      RST_IN,
   input  logic [P_MODE-1:0]         CFG_MODE_IN,
   input  logic                      CFG_STR_IN,
   input  logic                      CFG_ABRT_IN,
   output logic                      STA_BUSY_OUT,
   output logic                      STA_DONE_OUT,
   output logic [P_MODE+P_IDX-1:0]   ROM_SEL_OUT,
   input  logic [P_DAT-1:0]          ROM_DAT_IN,
   prt_scaler_coef_seq_if.master     coef
);
   localparam int CW = $clog2(P_FIFO) + 1;
   localparam int SW = CW + 1;
   localparam int FW = P_DAT + P_IDX + 1;
   localparam logic [SW-1:0] FIFO_CAP = SW'(P_FIFO);

   state_e                    state_q, state_d;
   logic [P_MODE-1:0]         mode_q, mode_d;
   logic [P_IDX-1:0]          idx_q, idx_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic [P_MODE+P_IDX-1:0]   sel_q, sel_d;

   logic [P_LAT:0]            tag_vld_q, tag_vld_d;
   logic [P_LAT:0]            tag_lst_q, tag_lst_d;
   logic [P_IDX-1:0]          tag_idx_q [P_LAT+1];
   logic [P_IDX-1:0]          tag_idx_d [P_LAT+1];

   logic [P_IDX-1:0]          n_cur;
   logic [SW-1:0]             inflight;
   logic                      issue;
   logic                      hs;

   logic                      fifo_wr, fifo_rd, fifo_empty;
   logic [FW-1:0]             fifo_wdata, fifo_rdata;
   logic [CW-1:0]             fifo_cnt;

   assign n_cur = P_IDX'(coef_cnt(mode_q));
   assign hs    = !fifo_empty && coef.COEF_RDY_IN;

   // Credit: every issued read already owns a FIFO slot, so backpressure never loses data.
   always_comb begin
      inflight = '0;
      for (int i = 0; i <= P_LAT; i++) begin
         inflight = inflight + SW'(tag_vld_q[i]);
      end
      issue = (state_q == ST_FETCH) && !CFG_ABRT_IN
              && ((SW'(fifo_cnt) + inflight) < FIFO_CAP);
   end

   always_comb begin
      tag_vld_d    = {tag_vld_q[P_LAT-1:0], issue};
      tag_lst_d    = {tag_lst_q[P_LAT-1:0], (idx_q == n_cur)};
      tag_idx_d[0] = idx_q;
      for (int i = 1; i <= P_LAT; i++) begin
         tag_idx_d[i] = tag_idx_q[i-1];
      end
      if (CFG_ABRT_IN) begin
         tag_vld_d = '0;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sel_d   = {mode_q, {P_IDX{1'b0}}};
      if (CFG_ABRT_IN) begin
         state_d = ST_IDLE;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (CFG_STR_IN) begin
                  mode_d  = CFG_MODE_IN;
                  idx_d   = P_IDX'(1);
                  busy_d  = 1'b1;
                  state_d = ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (issue) begin
                  sel_d = {mode_q, idx_q};
                  if (idx_q == n_cur) begin
                     state_d = ST_DRAIN;
                  end else begin
                     idx_d = idx_q + P_IDX'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (hs && fifo_rdata[0]) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK_IN or negedge RST_IN) begin
      if (!RST_IN) begin
         state_q   <= ST_IDLE;
         mode_q    <= '0;
         idx_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sel_q     <= '0;
         tag_vld_q <= '0;
         tag_lst_q <= '0;
         for (int i = 0; i <= P_LAT; i++) begin
            tag_idx_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         idx_q     <= idx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sel_q     <= sel_d;
         tag_vld_q <= tag_vld_d;
         tag_lst_q <= tag_lst_d;
         for (int i = 0; i <= P_LAT; i++) begin
            tag_idx_q[i] <= tag_idx_d[i];
         end
      end
   end

   // The oldest tag lines up with the ROM word returned for it this cycle.
   assign fifo_wr    = tag_vld_q[P_LAT] && !CFG_ABRT_IN;
   assign fifo_wdata = {ROM_DAT_IN, tag_idx_q[P_LAT], tag_lst_q[P_LAT]};
   assign fifo_rd    = hs;

   prt_scaler_coef_fifo #(
      .P_W     (FW),
      .P_DEPTH (P_FIFO)
   ) u_fifo (
      .clk     (CLK_IN),
      .rst_n   (RST_IN),
      .flush   (CFG_ABRT_IN),
      .wr_en   (fifo_wr),
      .wr_data (fifo_wdata),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rdata),
      .empty   (fifo_empty),
      .count   (fifo_cnt)
   );

   assign STA_BUSY_OUT      = busy_q;
   assign STA_DONE_OUT      = done_q;
   assign ROM_SEL_OUT       = sel_q;
   assign coef.COEF_VLD_OUT = !fifo_empty;
   assign coef.COEF_DAT_OUT = fifo_empty ? '0 : fifo_rdata[FW-1 -: P_DAT];
   assign coef.COEF_IDX_OUT = fifo_empty ? '0 : fifo_rdata[P_IDX:1];
   assign coef.COEF_LST_OUT = !fifo_empty && fifo_rdata[0];

endmodule

// File: tb/tb_prt_scaler_coef_seq.sv
// tb/tb_prt_scaler_coef_seq.sv - directed self-checking bench for the coefficient sequencer
module tb_prt_scaler_coef_seq;
   import prt_scaler_pkg::*;

   typedef struct {
      logic [6:0] idx;
      logic [7:0] dat;
      logic       lst;
   } word_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] cfg_mode = 2'd0;
   logic       cfg_str = 1'b0;
   logic       cfg_abrt = 1'b0;
   logic       busy, done;
   logic [8:0] rom_sel;
   logic [8:0] rom_sel_r = 9'd0;
   logic [7:0] rom_dat = 8'd0;

   prt_scaler_coef_seq_if #(.P_IDX(7), .P_DAT(8)) coef_if ();

   always #5 clk = ~clk;

   prt_scaler_coef_seq dut (
      .CLK_IN       (clk),
      .RST_IN       (rst_n),
      .CFG_MODE_IN  (cfg_mode),
      .CFG_STR_IN   (cfg_str),
      .CFG_ABRT_IN  (cfg_abrt),
      .STA_BUSY_OUT (busy),
      .STA_DONE_OUT (done),
      .ROM_SEL_OUT  (rom_sel),
      .ROM_DAT_IN   (rom_dat),
      .coef         (coef_if)
   );

   function automatic logic [7:0] rom_fn(input logic [1:0] m, input logic [6:0] i);
      case ({m, i})
         9'h081:  return 8'd114;
         9'h082:  return 8'd64;
         9'h083:  return 8'd13;
         9'h1BC:  return 8'd252;
         9'h1CC:  return 8'd125;
         9'h002:  return 8'd128;
         default: return 8'((int'(m) * 61 + int'(i) * 29 + 7) & 255);
      endcase
   endfunction

   // Behavioural ROM: select register then data register.
   always @(posedge clk) begin
      rom_sel_r <= rom_sel;
      rom_dat   <= rom_fn(rom_sel_r[8:7], rom_sel_r[6:0]);
   end

   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;
   int         rdy_mode = 0;
   int         stable_err = 0;
   int         done_cnt = 0;
   int         done_cyc = 0;
   int         max_cnt = 0;
   int         s_cyc = 0;
   logic       pv = 1'b0, pr = 1'b1, p_lst = 1'b0;
   logic [7:0] p_dat = 8'd0;
   logic [6:0] p_idx = 7'd0;
   word_t      wq[$];
   int         wc[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      logic  r;
      word_t w;
      @(negedge clk);
      cyc++;
      if (pv && !pr && (coef_if.COEF_VLD_OUT !== 1'b1 || coef_if.COEF_DAT_OUT !== p_dat
                        || coef_if.COEF_IDX_OUT !== p_idx || coef_if.COEF_LST_OUT !== p_lst))
         stable_err++;
      case (rdy_mode)
         0:       r = 1'b1;
         1:       r = 1'($urandom_range(0, 1));
         default: r = 1'b0;
      endcase
      coef_if.COEF_RDY_IN = r;
      if (coef_if.COEF_VLD_OUT && r) begin
         w.idx = coef_if.COEF_IDX_OUT;
         w.dat = coef_if.COEF_DAT_OUT;
         w.lst = coef_if.COEF_LST_OUT;
         wq.push_back(w);
         wc.push_back(cyc);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (int'(dut.u_fifo.cnt_q) > max_cnt) max_cnt = int'(dut.u_fifo.cnt_q);
      pv    = coef_if.COEF_VLD_OUT;
      pr    = r;
      p_dat = coef_if.COEF_DAT_OUT;
      p_idx = coef_if.COEF_IDX_OUT;
      p_lst = coef_if.COEF_LST_OUT;
   endtask

   task automatic start(input logic [1:0] m);
      tick();
      cfg_mode = m;
      cfg_str  = 1'b1;
      tick();
      cfg_str  = 1'b0;
      s_cyc    = cyc;
   endtask

   task automatic wait_idle(input string tag, input int limit);
      for (int i = 0; i < limit && busy; i++) tick();
      chk(tag, 32'(busy), 32'd0);
   endtask

   task automatic wait_words(input string tag, input int n, input int limit);
      for (int i = 0; i < limit && wq.size() < n; i++) tick();
      chk(tag, 32'(wq.size() >= n), 32'd1);
   endtask

   function automatic int bad_words(input logic [1:0] m, input int n);
      int bad = 0;
      for (int i = 0; i < wq.size(); i++) begin
         if (wq[i].idx !== 7'(i + 1) || wq[i].dat !== rom_fn(m, 7'(i + 1))
             || wq[i].lst !== (i == n - 1))
            bad++;
      end
      return bad;
   endfunction

   task automatic clear_log();
      wq.delete();
      wc.delete();
      done_cnt = 0;
      max_cnt  = 0;
   endtask

   initial begin
      coef_if.COEF_RDY_IN = 1'b1;
      repeat (3) tick();
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst sel", 32'(rom_sel), 0);
      chk("rst vld", 32'(coef_if.COEF_VLD_OUT), 0);
      chk("rst dat", 32'(coef_if.COEF_DAT_OUT), 0);
      rst_n = 1'b1;
      tick();

      // Mode 1, always ready: latency, throughput and done timing.
      clear_log();
      rdy_mode = 0;
      start(MODE_2_1);
      chk("m1 busy rise", 32'(busy), 1);
      tick();
      chk("m1 first sel", 32'(rom_sel), 32'h081);
      wait_idle("m1 finish", 100);
      chk("m1 count", wq.size(), 3);
      chk("m1 words", bad_words(MODE_2_1, 3), 0);
      chk("m1 dat1", 32'(wq[0].dat), 114);
      chk("m1 dat2", 32'(wq[1].dat), 64);
      chk("m1 dat3", 32'(wq[2].dat), 13);
      chk("m1 lst3", 32'(wq[2].lst), 1);
      chk("m1 latency", wc[0] - s_cyc, 4);
      chk("m1 gap12", wc[1] - wc[0], 1);
      chk("m1 gap23", wc[2] - wc[1], 1);
      chk("m1 done delay", done_cyc - wc[2], 1);
      chk("m1 done count", done_cnt, 1);

      // Mode 3, random ready.
      tick();
      clear_log();
      rdy_mode = 1;
      start(MODE_4_3);
      wait_idle("m3 finish", 2000);
      rdy_mode = 0;
      chk("m3 count", wq.size(), 76);
      chk("m3 words", bad_words(MODE_4_3, 76), 0);
      chk("m3 idx60", 32'(wq[59].dat), 252);
      chk("m3 idx76", 32'(wq[75].dat), 125);
      chk("m3 lst76", 32'(wq[75].lst), 1);
      chk("m3 fifo max", 32'(max_cnt <= 8), 1);
      chk("m3 done count", done_cnt, 1);
      chk("m3 stable", stable_err, 0);

      // Mode 0, backpressure after the first word.
      tick();
      clear_log();
      rdy_mode = 0;
      start(MODE_3_2);
      wait_words("m0 first word", 1, 50);
      rdy_mode = 2;
      repeat (20) tick();
      chk("m0 hold vld", 32'(coef_if.COEF_VLD_OUT), 1);
      chk("m0 hold idx", 32'(coef_if.COEF_IDX_OUT), 2);
      chk("m0 hold dat", 32'(coef_if.COEF_DAT_OUT), 128);
      chk("m0 stall sel", 32'(rom_sel), 0);
      chk("m0 fifo full", max_cnt, 8);
      chk("m0 count held", wq.size(), 1);
      chk("m0 stable", stable_err, 0);
      rdy_mode = 0;
      wait_idle("m0 finish", 200);
      chk("m0 count", wq.size(), 17);
      chk("m0 words", bad_words(MODE_3_2, 17), 0);
      chk("m0 idx2", 32'(wq[1].dat), 128);

      // Abort at idx 5 of mode 2, then restart in mode 1.
      tick();
      clear_log();
      start(MODE_3_1);
      wait_words("m2 reach idx5", 5, 50);
      cfg_abrt = 1'b1;
      tick();
      cfg_abrt = 1'b0;
      chk("abrt busy", 32'(busy), 0);
      chk("abrt vld", 32'(coef_if.COEF_VLD_OUT), 0);
      chk("abrt done", 32'(done), 0);
      repeat (6) tick();
      chk("abrt no done", done_cnt, 0);
      chk("abrt no words", wq.size(), 5);
      clear_log();
      start(MODE_2_1);
      wait_idle("abrt restart", 100);
      chk("restart count", wq.size(), 3);
      chk("restart words", bad_words(MODE_2_1, 3), 0);

      // Start while busy is ignored.
      tick();
      clear_log();
      start(MODE_3_1);
      tick();
      tick();
      cfg_mode = MODE_4_3;
      cfg_str  = 1'b1;
      tick();
      cfg_str  = 1'b0;
      wait_idle("busy str finish", 200);
      chk("busy str count", wq.size(), 11);
      chk("busy str words", bad_words(MODE_3_1, 11), 0);
      chk("busy str done", done_cnt, 1);

      // Abort and start together from idle: nothing starts.
      tick();
      clear_log();
      cfg_mode = MODE_2_1;
      cfg_str  = 1'b1;
      cfg_abrt = 1'b1;
      tick();
      cfg_str  = 1'b0;
      cfg_abrt = 1'b0;
      chk("abrt+str busy", 32'(busy), 0);
      repeat (8) tick();
      chk("abrt+str words", wq.size(), 0);
      chk("abrt+str done", done_cnt, 0);

      // Asynchronous reset mid-fetch.
      clear_log();
      start(MODE_4_3);
      repeat (8) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst busy", 32'(busy), 0);
      chk("arst sel", 32'(rom_sel), 0);
      chk("arst vld", 32'(coef_if.COEF_VLD_OUT), 0);
      chk("arst dat", 32'(coef_if.COEF_DAT_OUT), 0);
      chk("arst idx", 32'(coef_if.COEF_IDX_OUT), 0);
      chk("arst lst", 32'(coef_if.COEF_LST_OUT), 0);
      chk("arst done", 32'(done), 0);
      tick();
      tick();
      rst_n = 1'b1;
      clear_log();
      start(MODE_2_1);
      wait_idle("post rst finish", 100);
      chk("post rst count", wq.size(), 3);
      chk("post rst words", bad_words(MODE_2_1, 3), 0);
      chk("post rst done", done_cnt, 1);
      chk("final stable", stable_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
